// File: rtl/latrnq_bank_write_ctrl_if.sv
// Write-request and latch-bank signals of the latch bank write controller.
// The master drives requests and observes the bank side. The slave is the
// controller itself.
interface latrnq_bank_write_ctrl_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
);

  logic             wr_valid;
  logic             wr_ready;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             clr_req;
  logic [WIDTH-1:0] ld;
  logic [DEPTH-1:0] le;
  logic             lrn;
  logic             addr_err;
  logic             busy;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    output clr_req,
    input  wr_ready,
    input  ld,
    input  le,
    input  lrn,
    input  addr_err,
    input  busy
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    input  clr_req,
    output wr_ready,
    output ld,
    output le,
    output lrn,
    output addr_err,
    output busy
  );

endinterface

// File: rtl/latrnq_bank_write_ctrl.sv
// Write sequencer for a bank of active-low-reset D-latches.
// A write request becomes a registered four-cycle sequence: D is set up on the
// accept edge, a single latch enable is pulsed for one cycle, then D is held one
// more cycle before the next request can be taken. It also owns the bank clear.
module latrnq_bank_write_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic                    clk,
  input  logic                    rn,
  latrnq_bank_write_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StOpen,
    StHold,
    StClear
  } state_e;

  // DEPTH widened by one bit so DEPTH == 2**AW still compares correctly.
  localparam logic [AW:0] DepthW = (AW+1)'(DEPTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ld_q, ld_d;
  logic [DEPTH-1:0] le_q, le_d;
  logic             lrn_q, lrn_d;
  logic             addr_err_q, addr_err_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             addr_ok_q, addr_ok_d;
  logic             in_range;

  assign in_range = ({1'b0, bus.wr_addr} < DepthW);

  // Sequencer next-state and registered-output decode.
  always_comb begin
    state_d    = state_q;
    ld_d       = ld_q;
    le_d       = '0;
    lrn_d      = 1'b1;
    addr_err_d = 1'b0;
    addr_d     = addr_q;
    addr_ok_d  = addr_ok_q;
    unique case (state_q)
      StIdle: begin
        if (bus.clr_req) begin
          // Clear wins over a simultaneous write.
          state_d = StClear;
          lrn_d   = 1'b0;
        end else if (bus.wr_valid) begin
          state_d    = StSetup;
          ld_d       = bus.wr_data;
          addr_d     = bus.wr_addr;
          addr_ok_d  = in_range;
          addr_err_d = ~in_range;
        end
      end
      StSetup: begin
        state_d = StOpen;
        // Out-of-range writes run the full sequence with no enable.
        if (addr_ok_q) begin
          le_d = DEPTH'(1) << addr_q;
        end
      end
      StOpen:  state_d = StHold;
      StHold:  state_d = StIdle;
      StClear: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and output flops; reset clears the bank and kills any enable at once.
  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      state_q    <= StIdle;
      ld_q       <= '0;
      le_q       <= '0;
      lrn_q      <= 1'b0;
      addr_err_q <= 1'b0;
      addr_q     <= '0;
      addr_ok_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_q       <= ld_d;
      le_q       <= le_d;
      lrn_q      <= lrn_d;
      addr_err_q <= addr_err_d;
      addr_q     <= addr_d;
      addr_ok_q  <= addr_ok_d;
    end
  end

  assign bus.ld       = ld_q;
  assign bus.le       = le_q;
  assign bus.lrn      = lrn_q;
  assign bus.addr_err = addr_err_q;
  assign bus.busy     = (state_q != StIdle);
  assign bus.wr_ready = (state_q == StIdle) & ~bus.clr_req;

endmodule

// File: tb/tb_latrnq_bank_write_ctrl.sv
// Directed bench for the latch bank write controller: a DEPTH=4 instance for
// the main sequences and a DEPTH=3 instance for the out-of-range write.
module tb_latrnq_bank_write_ctrl;

  logic clk = 1'b0;
  logic rn;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  latrnq_bank_write_ctrl_if #(.WIDTH(8), .DEPTH(4), .AW(2)) bus_a ();
  latrnq_bank_write_ctrl_if #(.WIDTH(8), .DEPTH(3), .AW(2)) bus_b ();

  latrnq_bank_write_ctrl #(.WIDTH(8), .DEPTH(4), .AW(2)) u_dut_a (
    .clk (clk),
    .rn  (rn),
    .bus (bus_a)
  );

  latrnq_bank_write_ctrl #(.WIDTH(8), .DEPTH(3), .AW(2)) u_dut_b (
    .clk (clk),
    .rn  (rn),
    .bus (bus_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    rn             = 1'b0;
    bus_a.wr_valid = 1'b0;
    bus_a.wr_addr  = '0;
    bus_a.wr_data  = '0;
    bus_a.clr_req  = 1'b0;
    bus_b.wr_valid = 1'b0;
    bus_b.wr_addr  = '0;
    bus_b.wr_data  = '0;
    bus_b.clr_req  = 1'b0;

    // Reset held for three cycles.
    repeat (3) @(negedge clk);
    check_eq("rst_le", bus_a.le, 4'b0000);
    check_eq("rst_ld", bus_a.ld, 8'h00);
    check_eq("rst_lrn", bus_a.lrn, 1'b0);
    check_eq("rst_addr_err", bus_a.addr_err, 1'b0);
    check_eq("rst_busy", bus_a.busy, 1'b0);
    rn = 1'b1;
    @(negedge clk);
    check_eq("rel_lrn", bus_a.lrn, 1'b1);
    check_eq("rel_ready", bus_a.wr_ready, 1'b1);
    check_eq("rel_busy", bus_a.busy, 1'b0);
    check_eq("rel_lrn_b", bus_b.lrn, 1'b1);

    // Single write addr=2 data=0xA5; inputs change right after accept.
    bus_a.wr_valid = 1'b1;
    bus_a.wr_addr  = 2'd2;
    bus_a.wr_data  = 8'hA5;
    #1 check_eq("w1_ready_pre", bus_a.wr_ready, 1'b1);
    @(negedge clk);
    check_eq("w1_t0_ld", bus_a.ld, 8'hA5);
    check_eq("w1_t0_le", bus_a.le, 4'b0000);
    check_eq("w1_t0_busy", bus_a.busy, 1'b1);
    check_eq("w1_t0_ready", bus_a.wr_ready, 1'b0);
    check_eq("w1_t0_err", bus_a.addr_err, 1'b0);
    bus_a.wr_valid = 1'b0;
    bus_a.wr_addr  = 2'd0;
    bus_a.wr_data  = 8'hFF;
    @(negedge clk);
    check_eq("w1_t1_le", bus_a.le, 4'b0100);
    check_eq("w1_t1_ld", bus_a.ld, 8'hA5);
    @(negedge clk);
    check_eq("w1_t2_le", bus_a.le, 4'b0000);
    check_eq("w1_t2_ld", bus_a.ld, 8'hA5);
    @(negedge clk);
    check_eq("w1_t3_ld", bus_a.ld, 8'hA5);
    check_eq("w1_t3_ready", bus_a.wr_ready, 1'b1);
    check_eq("w1_t3_busy", bus_a.busy, 1'b0);
    check_eq("w1_t3_le", bus_a.le, 4'b0000);

    // Back-to-back with wr_valid held: (0,0x11) then (3,0x33).
    bus_a.wr_valid = 1'b1;
    bus_a.wr_addr  = 2'd0;
    bus_a.wr_data  = 8'h11;
    @(negedge clk);
    check_eq("bb_t0_ld", bus_a.ld, 8'h11);
    bus_a.wr_addr = 2'd3;
    bus_a.wr_data = 8'h33;
    @(negedge clk);
    check_eq("bb_t1_le", bus_a.le, 4'b0001);
    @(negedge clk);
    check_eq("bb_t2_le", bus_a.le, 4'b0000);
    @(negedge clk);
    check_eq("bb_t3_ready", bus_a.wr_ready, 1'b1);
    check_eq("bb_t3_ld", bus_a.ld, 8'h11);
    check_eq("bb_t3_le", bus_a.le, 4'b0000);
    @(negedge clk);
    check_eq("bb_t4_ld", bus_a.ld, 8'h33);
    check_eq("bb_t4_busy", bus_a.busy, 1'b1);
    check_eq("bb_t4_le", bus_a.le, 4'b0000);
    bus_a.wr_valid = 1'b0;
    @(negedge clk);
    check_eq("bb_t5_le", bus_a.le, 4'b1000);
    @(negedge clk);
    check_eq("bb_t6_le", bus_a.le, 4'b0000);
    @(negedge clk);
    check_eq("bb_t7_busy", bus_a.busy, 1'b0);

    // Clear and write together: clear wins, write follows.
    bus_a.clr_req  = 1'b1;
    bus_a.wr_valid = 1'b1;
    bus_a.wr_addr  = 2'd1;
    bus_a.wr_data  = 8'h5A;
    #1 check_eq("clr_ready_req", bus_a.wr_ready, 1'b0);
    @(negedge clk);
    check_eq("clr_lrn", bus_a.lrn, 1'b0);
    check_eq("clr_ready", bus_a.wr_ready, 1'b0);
    check_eq("clr_busy", bus_a.busy, 1'b1);
    check_eq("clr_ld", bus_a.ld, 8'h33);
    check_eq("clr_le", bus_a.le, 4'b0000);
    bus_a.clr_req = 1'b0;
    @(negedge clk);
    check_eq("clr_done_lrn", bus_a.lrn, 1'b1);
    check_eq("clr_done_busy", bus_a.busy, 1'b0);
    check_eq("clr_done_ready", bus_a.wr_ready, 1'b1);
    check_eq("clr_done_ld", bus_a.ld, 8'h33);
    @(negedge clk);
    check_eq("clr_wr_ld", bus_a.ld, 8'h5A);
    check_eq("clr_wr_busy", bus_a.busy, 1'b1);
    bus_a.wr_valid = 1'b0;
    @(negedge clk);
    check_eq("clr_wr_le", bus_a.le, 4'b0010);
    repeat (2) @(negedge clk);
    check_eq("clr_wr_idle", bus_a.busy, 1'b0);

    // Out-of-range write on the DEPTH=3 instance.
    bus_b.wr_valid = 1'b1;
    bus_b.wr_addr  = 2'd3;
    bus_b.wr_data  = 8'h77;
    @(negedge clk);
    check_eq("oor_t0_err", bus_b.addr_err, 1'b1);
    check_eq("oor_t0_le", bus_b.le, 3'b000);
    check_eq("oor_t0_ld", bus_b.ld, 8'h77);
    bus_b.wr_valid = 1'b0;
    @(negedge clk);
    check_eq("oor_t1_err", bus_b.addr_err, 1'b0);
    check_eq("oor_t1_le", bus_b.le, 3'b000);
    check_eq("oor_t1_busy", bus_b.busy, 1'b1);
    @(negedge clk);
    check_eq("oor_t2_le", bus_b.le, 3'b000);
    @(negedge clk);
    check_eq("oor_t3_le", bus_b.le, 3'b000);
    check_eq("oor_t3_ready", bus_b.wr_ready, 1'b1);
    check_eq("oor_t3_busy", bus_b.busy, 1'b0);

    // Reset asserted while the enable is open.
    bus_a.wr_valid = 1'b1;
    bus_a.wr_addr  = 2'd1;
    bus_a.wr_data  = 8'hC3;
    @(negedge clk);
    bus_a.wr_valid = 1'b0;
    @(negedge clk);
    check_eq("ar_open_le", bus_a.le, 4'b0010);
    #2 rn = 1'b0;
    #1;
    check_eq("ar_le", bus_a.le, 4'b0000);
    check_eq("ar_lrn", bus_a.lrn, 1'b0);
    check_eq("ar_ld", bus_a.ld, 8'h00);
    check_eq("ar_busy", bus_a.busy, 1'b0);
    @(negedge clk);
    rn = 1'b1;
    @(negedge clk);
    check_eq("ar_rel_lrn", bus_a.lrn, 1'b1);
    check_eq("ar_rel_le", bus_a.le, 4'b0000);
    check_eq("ar_rel_busy", bus_a.busy, 1'b0);
    bus_a.wr_valid = 1'b1;
    bus_a.wr_addr  = 2'd2;
    bus_a.wr_data  = 8'h3C;
    @(negedge clk);
    check_eq("ar_wr_ld", bus_a.ld, 8'h3C);
    bus_a.wr_valid = 1'b0;
    @(negedge clk);
    check_eq("ar_wr_le", bus_a.le, 4'b0100);
    @(negedge clk);
    check_eq("ar_wr_le_off", bus_a.le, 4'b0000);
    @(negedge clk);
    check_eq("ar_wr_ready", bus_a.wr_ready, 1'b1);
    check_eq("ar_wr_ld_hold", bus_a.ld, 8'h3C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
